// File: rtl/scv_pkg.sv
// Shared constants and the access-owner tag for the Epoch TV-1 VRAM arbiter.
package scv_pkg;

   localparam int VRAM_AW = 11;
   localparam int VRAM_DW = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_REN  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

endpackage

// File: rtl/epochtv1_vram_port.sv
// VRAM pin driver: registers a one-cycle access command onto the pins, captures
// VD_I one cycle later and returns the read byte tagged with its owner.
module epochtv1_vram_port
   import scv_pkg::*;
(
   input  logic               clk_i,
   input  logic               res_i,
   input  owner_e             cmdOwner_i,
   input  logic [VRAM_AW:0]   cmdAddr_i,
   input  logic               cmdWr_i,
   input  logic [VRAM_DW-1:0] cmdData_i,
   input  logic [VRAM_DW-1:0] vdI_i,
   output logic [VRAM_AW-1:0] va_o,
   output logic [VRAM_DW-1:0] vdO_o,
   output logic               nVwe_o,
   output logic [1:0]         nVcs_o,
   output owner_e             rdOwner_o,
   output logic [VRAM_DW-1:0] renData_o,
   output logic [VRAM_DW-1:0] cpuData_o,
   output logic               cpuDone_o
);

   owner_e             own1_q;
   owner_e             own2_q;
   owner_e             rdOwner_q;
   logic               wr1_q;
   logic [VRAM_AW-1:0] va_q;
   logic [VRAM_DW-1:0] vdO_q;
   logic               nVwe_q;
   logic [1:0]         nVcs_q;
   logic [VRAM_DW-1:0] renData_q;
   logic [VRAM_DW-1:0] cpuData_q;

   // Stage 1 drives the pins, stage 2 sees the RAM data, stage 3 returns it.
   // Writes leave the pipe after stage 1, so only reads reach stage 2.
   always_ff @(posedge clk_i) begin
      if (res_i) begin
         own1_q    <= OWN_NONE;
         own2_q    <= OWN_NONE;
         rdOwner_q <= OWN_NONE;
         wr1_q     <= 1'b0;
         va_q      <= '0;
         vdO_q     <= '0;
         nVwe_q    <= 1'b1;
         nVcs_q    <= 2'b11;
         renData_q <= '0;
         cpuData_q <= '0;
      end else begin
         own1_q    <= cmdOwner_i;
         wr1_q     <= cmdWr_i && (cmdOwner_i != OWN_NONE);
         own2_q    <= wr1_q ? OWN_NONE : own1_q;
         rdOwner_q <= own2_q;
         if (cmdOwner_i != OWN_NONE) begin
            va_q   <= cmdAddr_i[VRAM_AW-1:0];
            nVcs_q <= cmdAddr_i[VRAM_AW] ? 2'b01 : 2'b10;
            nVwe_q <= !cmdWr_i;
            if (cmdWr_i)
               vdO_q <= cmdData_i;
         end else begin
            nVcs_q <= 2'b11;
            nVwe_q <= 1'b1;
         end
         if (own2_q == OWN_REN)
            renData_q <= vdI_i;
         if (own2_q == OWN_CPU)
            cpuData_q <= vdI_i;
      end
   end

   assign va_o      = va_q;
   assign vdO_o     = vdO_q;
   assign nVwe_o    = nVwe_q;
   assign nVcs_o    = nVcs_q;
   assign rdOwner_o = rdOwner_q;
   assign renData_o = renData_q;
   assign cpuData_o = cpuData_q;
   assign cpuDone_o = ((own1_q == OWN_CPU) && wr1_q) || (own2_q == OWN_CPU);

endmodule

// File: rtl/epochtv1_vram_arb.sv
// Epoch TV-1 VRAM arbiter: one access per CE slot, renderer first, with a
// starve counter that forces a waiting CPU access through after STARVE_MAX losses.
module epochtv1_vram_arb
   import scv_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RES,
   input  logic        CE,
   input  logic [11:0] CPU_A,
   input  logic [7:0]  CPU_DI,
   input  logic        CPU_WR,
   input  logic        CPU_RD,
   output logic        CPU_BUSY,
   output logic [7:0]  CPU_DO,
   output logic        CPU_RVALID,
   input  logic        REN_REQ,
   input  logic [11:0] REN_A,
   output logic        REN_ACK,
   output logic [7:0]  REN_D,
   output logic        REN_DVALID,
   output logic [10:0] VA,
   input  logic [7:0]  VD_I,
   output logic [7:0]  VD_O,
   output logic        nVWE,
   output logic [1:0]  nVCS
);

   logic        pend_q;
   logic        busy_q;
   logic        bufWr_q;
   logic [11:0] bufA_q;
   logic [7:0]  bufD_q;
   logic [3:0]  starve_q;

   logic        cpuStarved;
   logic        renGrant;
   logic        cpuGrant;
   logic        cpuDone;
   owner_e      cmdOwner;
   owner_e      rdOwner;

   // The buffered request is only visible from the cycle after capture, so a
   // request arriving on a CE cycle waits for the following slot.
   assign cpuStarved = pend_q && (starve_q == 4'(STARVE_MAX));
   assign renGrant   = !RES && CE && REN_REQ && !cpuStarved;
   assign cpuGrant   = !RES && CE && pend_q && !renGrant;

   always_comb begin
      cmdOwner = OWN_NONE;
      if (renGrant)
         cmdOwner = OWN_REN;
      else if (cpuGrant)
         cmdOwner = OWN_CPU;
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         pend_q   <= 1'b0;
         busy_q   <= 1'b0;
         bufWr_q  <= 1'b0;
         bufA_q   <= '0;
         bufD_q   <= '0;
         starve_q <= '0;
      end else begin
         if (!busy_q && (CPU_WR || CPU_RD)) begin
            pend_q  <= 1'b1;
            busy_q  <= 1'b1;
            bufWr_q <= CPU_WR;
            bufA_q  <= CPU_A;
            bufD_q  <= CPU_DI;
         end else begin
            if (cpuGrant)
               pend_q <= 1'b0;
            if (cpuDone)
               busy_q <= 1'b0;
         end
         if (!pend_q || cpuGrant)
            starve_q <= '0;
         else if (renGrant && (starve_q < 4'(STARVE_MAX)))
            starve_q <= starve_q + 4'd1;
      end
   end

   epochtv1_vram_port uPort (
      .clk_i      (CLK),
      .res_i      (RES),
      .cmdOwner_i (cmdOwner),
      .cmdAddr_i  (renGrant ? REN_A : bufA_q),
      .cmdWr_i    (cpuGrant && bufWr_q),
      .cmdData_i  (bufD_q),
      .vdI_i      (VD_I),
      .va_o       (VA),
      .vdO_o      (VD_O),
      .nVwe_o     (nVWE),
      .nVcs_o     (nVCS),
      .rdOwner_o  (rdOwner),
      .renData_o  (REN_D),
      .cpuData_o  (CPU_DO),
      .cpuDone_o  (cpuDone)
   );

   assign REN_ACK    = renGrant;
   assign REN_DVALID = (rdOwner == OWN_REN);
   assign CPU_RVALID = (rdOwner == OWN_CPU);
   assign CPU_BUSY   = busy_q;

endmodule

// File: tb/tb_epochtv1_vram_arb.sv
// Randomized bench for the VRAM arbiter: a slot-level reference model predicts
// grants, pin activity and returned data; a synchronous RAM model sits on the pins.
module tb_epochtv1_vram_arb;

   localparam int STARVE = 4;

   logic        CLK = 1'b0;
   logic        RES, CE, CPU_WR, CPU_RD, REN_REQ;
   logic [11:0] CPU_A, REN_A;
   logic [7:0]  CPU_DI, VD_I, VD_O, CPU_DO, REN_D;
   logic        CPU_BUSY, CPU_RVALID, REN_ACK, REN_DVALID, nVWE;
   logic [10:0] VA;
   logic [1:0]  nVCS;

   epochtv1_vram_arb #(.STARVE_MAX(STARVE)) dut (
      .CLK(CLK), .RES(RES), .CE(CE),
      .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_WR(CPU_WR), .CPU_RD(CPU_RD),
      .CPU_BUSY(CPU_BUSY), .CPU_DO(CPU_DO), .CPU_RVALID(CPU_RVALID),
      .REN_REQ(REN_REQ), .REN_A(REN_A), .REN_ACK(REN_ACK),
      .REN_D(REN_D), .REN_DVALID(REN_DVALID),
      .VA(VA), .VD_I(VD_I), .VD_O(VD_O), .nVWE(nVWE), .nVCS(nVCS)
   );

   always #5 CLK = ~CLK;

   // Both VRAM chips as one array: index bit 11 selects chip B.
   logic [7:0] ram [4096];
   logic [7:0] vdq;
   logic       memLoad;

   function automatic logic [7:0] patternFn(int i);
      if (i == 'h805)
         return 8'h3C;
      return 8'(i * 29 + 7) ^ 8'(i >>> 5);
   endfunction

   always @(posedge CLK) begin
      if (memLoad) begin
         for (int i = 0; i < 4096; i++)
            ram[i] <= patternFn(i);
      end else if (nVCS[0] == 1'b0) begin
         if (nVWE == 1'b0)
            ram[{1'b0, VA}] <= VD_O;
         vdq <= ram[{1'b0, VA}];
      end else if (nVCS[1] == 1'b0) begin
         if (nVWE == 1'b0)
            ram[{1'b1, VA}] <= VD_O;
         vdq <= ram[{1'b1, VA}];
      end
   end
   assign VD_I = vdq;

   typedef struct {
      bit        pv;
      bit [10:0] va;
      bit [1:0]  cs;
      bit        we;
      bit [7:0]  vdo;
      bit        rv;
      bit        rcpu;
      bit [7:0]  rdata;
      bit        busyClr;
   } slot_t;

   slot_t     sched [8];
   bit [7:0]  modelMem [4096];
   bit        mBusy, mPend, mWr, modelValid;
   bit [11:0] mA;
   bit [7:0]  mD, mVDO, mRenD, mCpuDo;
   bit [10:0] mVA;
   int        mStarve, cyc, ceCnt;

   logic        nRes, nWr, nRd, nRenReq;
   logic [11:0] nA, nRenA;
   logic [7:0]  nDi;
   int          renMode;
   bit          cpuRand, seenWe;
   int          ackCnt, dvalidCnt, rvalidCnt, weLowCnt, activeCnt;
   logic [7:0]  lastRenD, lastCpuDo;
   int          checkCount, errorCount;

   task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // One clock: drive at the falling edge, check the model's view, then advance the model.
   task automatic applyStimulus();
      int        s;
      int        d;
      bit        expAck, cpuG, expWe, expRenV, expCpuV;
      bit [1:0]  expCs;
      bit [11:0] addr;
      @(negedge CLK);
      if (ceCnt == 0) begin
         CE    = 1'b1;
         ceCnt = $urandom_range(3, 6);
      end else begin
         CE = 1'b0;
         ceCnt--;
      end
      RES = nRes; REN_REQ = nRenReq; REN_A = nRenA;
      CPU_WR = nWr; CPU_RD = nRd; CPU_A = nA; CPU_DI = nDi;
      #1;
      s = cyc % 8;
      if (sched[s].busyClr)
         mBusy = 1'b0;
      expCs = 2'b11;
      expWe = 1'b1;
      if (sched[s].pv) begin
         expCs = sched[s].cs;
         expWe = sched[s].we;
         mVA   = sched[s].va;
         if (!sched[s].we)
            mVDO = sched[s].vdo;
      end
      expRenV = sched[s].rv && !sched[s].rcpu;
      expCpuV = sched[s].rv && sched[s].rcpu;
      if (expRenV)
         mRenD = sched[s].rdata;
      if (expCpuV)
         mCpuDo = sched[s].rdata;
      sched[s] = '{default: 0};
      expAck = !RES && CE && REN_REQ && !(mPend && mStarve == STARVE);

      if (REN_ACK === 1'b1) ackCnt++;
      if (REN_DVALID === 1'b1) begin dvalidCnt++; lastRenD = REN_D; end
      if (CPU_RVALID === 1'b1) begin rvalidCnt++; lastCpuDo = CPU_DO; end
      if (nVWE === 1'b0) begin weLowCnt++; seenWe = 1'b1; end
      if (nVCS !== 2'b11 || nVWE !== 1'b1) activeCnt++;

      if (modelValid) begin
         checkOutput("renAck", REN_ACK, expAck);
         checkOutput("nVCS", nVCS, expCs);
         checkOutput("nVWE", nVWE, expWe);
         checkOutput("VA", VA, mVA);
         checkOutput("VD_O", VD_O, mVDO);
         checkOutput("renDvalid", REN_DVALID, expRenV);
         checkOutput("renD", REN_D, mRenD);
         checkOutput("cpuRvalid", CPU_RVALID, expCpuV);
         checkOutput("cpuDo", CPU_DO, mCpuDo);
         checkOutput("cpuBusy", CPU_BUSY, mBusy);
      end

      if (RES) begin
         for (int i = 0; i < 8; i++)
            sched[i] = '{default: 0};
         mVA = '0; mVDO = '0; mRenD = '0; mCpuDo = '0;
         mBusy = 0; mPend = 0; mStarve = 0;
         modelValid = 1'b1;
      end else begin
         cpuG = CE && mPend && !expAck;
         if (expAck || cpuG) begin
            addr = expAck ? REN_A : mA;
            d = (cyc + 1) % 8;
            sched[d].pv  = 1'b1;
            sched[d].va  = addr[10:0];
            sched[d].cs  = addr[11] ? 2'b01 : 2'b10;
            sched[d].we  = !(cpuG && mWr);
            sched[d].vdo = mD;
            if (cpuG && mWr) begin
               modelMem[addr] = mD;
               sched[(cyc + 2) % 8].busyClr = 1'b1;
            end else begin
               d = (cyc + 3) % 8;
               sched[d].rv      = 1'b1;
               sched[d].rcpu    = cpuG;
               sched[d].rdata   = modelMem[addr];
               sched[d].busyClr = cpuG;
            end
         end
         if (expAck && mPend)
            mStarve++;
         if (cpuG || !mPend)
            mStarve = 0;
         if (cpuG)
            mPend = 1'b0;
         if (!mBusy && (CPU_WR || CPU_RD)) begin
            mPend = 1'b1; mBusy = 1'b1;
            mWr = CPU_WR; mA = CPU_A; mD = CPU_DI;
         end
      end
      cyc++;

      // Renderer keeps its request up until it sees REN_ACK.
      if (!REN_REQ || REN_ACK === 1'b1) begin
         case (renMode)
            1: begin nRenReq = 1'b1; nRenA = 12'($urandom_range(0, 4095)); end
            2: begin nRenReq = ($urandom_range(0, 3) == 0); nRenA = 12'($urandom_range(0, 4095)); end
            3: if (REN_ACK === 1'b1) begin nRenReq = 1'b0; renMode = 0; end
            default: nRenReq = 1'b0;
         endcase
      end
      nRes = 1'b0; nWr = 1'b0; nRd = 1'b0;
      if (cpuRand) begin
         nWr = ($urandom_range(0, 7) == 0);
         nRd = ($urandom_range(0, 7) == 0);
         nA  = 12'($urandom_range(0, 4095));
         nDi = 8'($urandom_range(0, 255));
      end
   endtask

   task automatic runCycles(int n);
      for (int i = 0; i < n; i++)
         applyStimulus();
   endtask

   task automatic waitBusyLow(string tag);
      int n = 0;
      while (CPU_BUSY === 1'b1 && n < 40) begin
         applyStimulus();
         n++;
      end
      if (CPU_BUSY !== 1'b0)
         checkOutput(tag, CPU_BUSY, 1'b0);
   endtask

   initial begin
      int base, n, bad;
      CE = 0; RES = 1; CPU_WR = 0; CPU_RD = 0; REN_REQ = 0;
      CPU_A = 0; REN_A = 0; CPU_DI = 0;
      nRes = 1; nWr = 0; nRd = 0; nRenReq = 0; nA = 0; nRenA = 0; nDi = 0;
      memLoad = 1; renMode = 0; cpuRand = 0; ceCnt = 2; cyc = 0; modelValid = 0;
      ackCnt = 0; dvalidCnt = 0; rvalidCnt = 0; weLowCnt = 0; activeCnt = 0;
      lastRenD = 0; lastCpuDo = 0; checkCount = 0; errorCount = 0; seenWe = 0;
      for (int i = 0; i < 4096; i++)
         modelMem[i] = patternFn(i);
      for (int i = 0; i < 8; i++)
         sched[i] = '{default: 0};

      applyStimulus();
      memLoad = 0;
      nRes = 1;
      applyStimulus();
      runCycles(4);

      $display("[TB] renderer-only fetch");
      nRenReq = 1; nRenA = 12'h805; renMode = 3;
      runCycles(16);
      checkOutput("renOnlyData", lastRenD, 8'h3C);

      $display("[TB] CPU write then read");
      base = weLowCnt;
      nWr = 1; nA = 12'h012; nDi = 8'hA5;
      runCycles(2);
      waitBusyLow("wrBusyTimeout");
      checkOutput("wrStrobeLen", weLowCnt - base, 1);
      base = rvalidCnt;
      nRd = 1; nA = 12'h012;
      runCycles(2);
      waitBusyLow("rdBusyTimeout");
      checkOutput("rdData", lastCpuDo, 8'hA5);
      checkOutput("rdPulses", rvalidCnt - base, 1);
      checkOutput("ramWrite", ram[12'h012], 8'hA5);

      $display("[TB] starvation");
      nRenReq = 1; nRenA = 12'h400; renMode = 1;
      runCycles(10);
      nWr = 1; nA = 12'h0F0; nDi = 8'h77;
      applyStimulus();
      base = ackCnt; seenWe = 0; n = 0;
      while (!seenWe && n < 80) begin
         applyStimulus();
         n++;
      end
      checkOutput("starveCpuSlot", seenWe, 1'b1);
      checkOutput("starveAcks", ackCnt - base, STARVE);
      base = ackCnt;
      runCycles(8);
      checkOutput("renResume", (ackCnt - base) > 0, 1'b1);

      $display("[TB] drop rules");
      renMode = 0;
      n = 0;
      while (REN_REQ === 1'b1 && n < 20) begin
         applyStimulus();
         n++;
      end
      waitBusyLow("dropIdleTimeout");
      base = rvalidCnt;
      nWr = 1; nRd = 1; nA = 12'h123; nDi = 8'h5A;
      applyStimulus();
      nWr = 1; nA = 12'h124; nDi = 8'hC3;
      applyStimulus();
      waitBusyLow("dropBusyTimeout");
      runCycles(6);
      checkOutput("dropFirstWr", ram[12'h123], 8'h5A);
      checkOutput("dropSecondWr", ram[12'h124], patternFn(12'h124));
      checkOutput("dropNoRvalid", rvalidCnt - base, 0);

      $display("[TB] reset mid-access");
      nRenReq = 1; nRenA = 12'h321; renMode = 3;
      n = 0;
      do begin
         applyStimulus();
         n++;
      end while (REN_ACK !== 1'b1 && n < 20);
      checkOutput("rstAckSeen", REN_ACK, 1'b1);
      base = dvalidCnt;
      nRes = 1;
      runCycles(6);
      checkOutput("rstNoDvalid", dvalidCnt - base, 0);

      $display("[TB] idle slots");
      base = activeCnt;
      runCycles(140);
      checkOutput("idlePins", activeCnt - base, 0);

      $display("[TB] random traffic");
      renMode = 2; cpuRand = 1;
      runCycles(3000);
      renMode = 0; cpuRand = 0;
      runCycles(30);
      bad = 0;
      for (int i = 0; i < 4096; i++)
         if (ram[i] !== modelMem[i])
            bad++;
      checkOutput("memImage", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
